// File: rtl/apb_cmd_master_pkg.sv
// Shared types and constants for the APB command requester and its helpers.
package apb_cmd_master_pkg;

  localparam int unsigned PKG_DATA_W = 32;
  localparam int unsigned PKG_ADDR_W = 32;
  localparam int unsigned PKG_STRB_W = PKG_DATA_W / 8;

  localparam logic [2:0] PPROT_DEFAULT = 3'b000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [PKG_ADDR_W-1:0] addr;
    logic [PKG_DATA_W-1:0] wdata;
    logic                  write;
    logic [PKG_STRB_W-1:0] strb;
  } cmd_t;

  typedef struct packed {
    logic [PKG_DATA_W-1:0] rdata;
    logic                  slverr;
    logic                  timeout;
  } rsp_t;

  // Wait-counter width; a disabled timeout still needs a legal 1-bit vector.
  function automatic int unsigned timer_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command/response stream plus APB4 requester pins of apb_cmd_master.
interface apb_cmd_master_if
  import apb_cmd_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PKG_DATA_W,
  parameter int unsigned ADDR_WIDTH = PKG_ADDR_W
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  cmd_write;
  logic [STRB_WIDTH-1:0] cmd_strb;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_slverr;
  logic                  rsp_timeout;

  logic [ADDR_WIDTH-1:0] m_paddr;
  logic [DATA_WIDTH-1:0] m_pwdata;
  logic                  m_pwrite;
  logic [STRB_WIDTH-1:0] m_pstrb;
  logic [2:0]            m_pprot;
  logic                  m_psel;
  logic                  m_penable;
  logic [DATA_WIDTH-1:0] m_prdata;
  logic                  m_pready;
  logic                  m_pslverr;

  // Requester side: consumes commands, produces responses, drives APB.
  modport master (
    input  cmd_valid, cmd_addr, cmd_wdata, cmd_write, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    input  rsp_ready,
    output m_paddr, m_pwdata, m_pwrite, m_pstrb, m_pprot, m_psel, m_penable,
    input  m_prdata, m_pready, m_pslverr
  );

  // Environment side: command source, response sink and APB completer.
  modport slave (
    output cmd_valid, cmd_addr, cmd_wdata, cmd_write, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    output rsp_ready,
    input  m_paddr, m_pwdata, m_pwrite, m_pstrb, m_pprot, m_psel, m_penable,
    output m_prdata, m_pready, m_pslverr
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Loadable saturating down-counter bounding APB wait states; expired at zero.
module apb_wait_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired_c
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired_c = (count == '0);

endmodule

// File: rtl/apb_cmd_master.sv
// APB4 requester: one valid/ready command becomes one APB transfer and one response.
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = PKG_DATA_W,
  parameter int unsigned ADDR_WIDTH     = PKG_ADDR_W,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rstn,
  apb_cmd_master_if.master    bus
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned TMR_W      = timer_width(TIMEOUT_CYCLES);
  localparam int unsigned TMR_LOAD   = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t state;
  cmd_t   cmd_q;
  rsp_t   rsp_q;
  logic   cmd_ready_q;
  logic   rsp_valid_q;
  logic   psel_q;
  logic   penable_q;

  logic   tmr_clear_c;
  logic   tmr_load_c;
  logic   tmr_en_c;
  logic   tmr_expired_c;
  logic   timeout_c;

  // Timer is armed while in SETUP so it holds the full budget on ACCESS entry.
  assign tmr_clear_c = (state == IDLE);
  assign tmr_load_c  = (state == SETUP);
  assign tmr_en_c    = (state == ACCESS) && !bus.m_pready;
  assign timeout_c   = TIMEOUT_EN && tmr_expired_c;

  apb_wait_timer #(
    .WIDTH (TMR_W)
  ) u_wait_timer (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (tmr_clear_c),
    .load       (tmr_load_c),
    .load_value (TMR_W'(TMR_LOAD)),
    .enable     (tmr_en_c),
    .expired_c  (tmr_expired_c)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      cmd_q       <= '0;
      rsp_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            cmd_q.addr  <= PKG_ADDR_W'(bus.cmd_addr);
            cmd_q.wdata <= PKG_DATA_W'(bus.cmd_wdata);
            cmd_q.write <= bus.cmd_write;
            // APB4 requires zero strobes on reads.
            cmd_q.strb  <= bus.cmd_write ? PKG_STRB_W'(bus.cmd_strb) : '0;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            state       <= SETUP;
          end
        end

        SETUP: begin
          penable_q <= 1'b1;
          state     <= ACCESS;
        end

        ACCESS: begin
          // A completion in the last allowed cycle takes priority over the timeout.
          if (bus.m_pready) begin
            rsp_q.rdata   <= cmd_q.write ? '0 : PKG_DATA_W'(bus.m_prdata);
            rsp_q.slverr  <= bus.m_pslverr;
            rsp_q.timeout <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state         <= RESP;
          end else if (timeout_c) begin
            rsp_q.rdata   <= '0;
            rsp_q.slverr  <= 1'b1;
            rsp_q.timeout <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state         <= RESP;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = DATA_WIDTH'(rsp_q.rdata);
  assign bus.rsp_slverr  = rsp_q.slverr;
  assign bus.rsp_timeout = rsp_q.timeout;

  assign bus.m_paddr     = ADDR_WIDTH'(cmd_q.addr);
  assign bus.m_pwdata    = DATA_WIDTH'(cmd_q.wdata);
  assign bus.m_pwrite    = cmd_q.write;
  assign bus.m_pstrb     = STRB_WIDTH'(cmd_q.strb);
  assign bus.m_pprot     = PPROT_DEFAULT;
  assign bus.m_psel      = psel_q;
  assign bus.m_penable   = penable_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: random commands, modelled APB completer, response monitor.
module tb_apb_cmd_master;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned SW  = DW / 8;
  localparam int          TMO = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_cmd_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  apb_cmd_master #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // One command plus how the modelled completer answers it.
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          write;
    logic [SW-1:0] strb;
    int            waits;
    logic [DW-1:0] rdata;
    logic          slverr;
    int            setup_cyc;
  } plan_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          slverr;
    logic          timeout;
    int            valid_cyc;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h cyc=%0d", name, act, want, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: cyc=%0d", name, cyc);
  endtask

  // Reference: waits >= TMO means timeout after TMO access cycles, else waits+1 access cycles.
  function automatic exp_t model(input plan_t p);
    exp_t e;
    int   acc;
    if (p.waits >= TMO) begin
      e.rdata   = '0;
      e.slverr  = 1'b1;
      e.timeout = 1'b1;
      acc       = TMO;
    end else begin
      e.rdata   = p.write ? '0 : p.rdata;
      e.slverr  = p.slverr;
      e.timeout = 1'b0;
      acc       = p.waits + 1;
    end
    e.valid_cyc = p.setup_cyc + 1 + acc;
    return e;
  endfunction

  function automatic plan_t mk(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic write, input logic [SW-1:0] strb, input int waits,
                               input logic [DW-1:0] rdata, input logic slverr);
    plan_t p;
    p.addr = addr; p.wdata = wdata; p.write = write; p.strb = strb;
    p.waits = waits; p.rdata = rdata; p.slverr = slverr; p.setup_cyc = 0;
    return p;
  endfunction

  function automatic plan_t rand_plan();
    int w;
    w = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TMO, TMO + 3)) : int'($urandom_range(0, TMO - 1));
    return mk(AW'($urandom), DW'($urandom), 1'($urandom), SW'($urandom), w, DW'($urandom),
              $urandom_range(0, 3) == 0);
  endfunction

  task automatic drive_junk();
    bus.cmd_addr  = AW'($urandom);
    bus.cmd_wdata = DW'($urandom);
    bus.cmd_write = 1'($urandom);
    bus.cmd_strb  = SW'($urandom);
  endtask

  // Called at a negedge; junk on the bus until cmd_ready is seen, then the real command.
  task automatic send(input plan_t p_in);
    plan_t p;
    bit    done;
    int    n;
    p = p_in; done = 0; n = 0;
    bus.cmd_valid = 1'b1;
    while (!done && n < 200) begin
      if (bus.cmd_ready === 1'b1) begin
        bus.cmd_addr  = p.addr;
        bus.cmd_wdata = p.wdata;
        bus.cmd_write = p.write;
        bus.cmd_strb  = p.strb;
        p.setup_cyc   = cyc + 1;
        plan_q.push_back(p);
        exp_q.push_back(model(p));
        done = 1;
      end else begin
        drive_junk();
      end
      @(negedge clk);
      n++;
    end
    if (!done) fail_now("cmd_accept_wait");
    bus.cmd_valid = 1'b0;
    drive_junk();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && plan_q.size() == 0 && bus.rsp_valid === 1'b0 &&
             bus.cmd_ready === 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail_now("drain_wait");
  endtask

  // Stimulus and directed phases.
  initial begin : driver
    int n;
    bus.cmd_valid = 1'b0;
    drive_junk();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 1);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 0);
    check("rst_psel", 64'(bus.m_psel), 0);
    check("rst_penable", 64'(bus.m_penable), 0);
    check("rst_paddr", 64'(bus.m_paddr), 0);
    check("rst_pwdata", 64'(bus.m_pwdata), 0);
    check("rst_pstrb", 64'(bus.m_pstrb), 0);
    check("rst_pwrite", 64'(bus.m_pwrite), 0);
    check("rst_rsp_fields", {bus.rsp_rdata, bus.rsp_slverr, bus.rsp_timeout}, 0);
    rstn = 1'b1;
    @(negedge clk);

    send(mk(32'h4,  32'hDEADBEEF, 1'b1, 4'hF, 0, 32'hA5A5A5A5, 1'b0));
    send(mk(32'h8,  32'h0,        1'b0, 4'hF, 2, 32'h12345678, 1'b0));
    send(mk(32'hC,  32'h0,        1'b0, 4'h3, 0, 32'h00000055, 1'b1));
    send(mk(32'h10, 32'h0,        1'b0, 4'hF, TMO + 5, 32'h77, 1'b0));
    send(mk(32'h14, 32'h0,        1'b0, 4'hF, TMO - 1, 32'hCAFEF00D, 1'b0));
    send(mk(32'h18, 32'h13572468, 1'b1, 4'h5, TMO, 32'h99, 1'b0));

    repeat (60) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(rand_plan());
    end
    wait_drain();

    // Reset while the completer is still holding pready low.
    send(mk(32'h20, 32'h11, 1'b0, 4'hF, TMO - 1, 32'h99, 1'b0));
    n = 0;
    while (!(bus.m_psel === 1'b1 && bus.m_penable === 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) fail_now("reach_access");
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("midrst_psel", 64'(bus.m_psel), 0);
    check("midrst_penable", 64'(bus.m_penable), 0);
    check("midrst_rsp_valid", 64'(bus.rsp_valid), 0);
    check("midrst_cmd_ready", 64'(bus.cmd_ready), 1);
    exp_q.delete();
    plan_q.delete();
    repeat (6) begin
      @(negedge clk);
      check("aborted_no_rsp", 64'(bus.rsp_valid), 0);
    end

    send(mk(32'h24, 32'h2468ACE0, 1'b1, 4'hC, 1, 32'h0, 1'b0));
    wait_drain();
    check("final_exp_empty", 64'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // APB completer: pready rises on the access cycle the plan names; junk elsewhere.
  initial begin : completer
    plan_t p;
    bit    have;
    int    acc;
    have = 0; acc = 0;
    bus.m_pready  = 1'b0;
    bus.m_prdata  = '0;
    bus.m_pslverr = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        have = 0;
        continue;
      end
      if (bus.m_psel === 1'b1 && bus.m_penable === 1'b0) begin
        if (plan_q.size() == 0) begin
          fail_now("setup_without_cmd");
          have = 0;
        end else begin
          p = plan_q.pop_front();
          have = 1;
          acc = 0;
          check("setup_cycle", 64'(cyc), 64'(p.setup_cyc));
          check("setup_paddr", 64'(bus.m_paddr), 64'(p.addr));
          check("setup_pwdata", 64'(bus.m_pwdata), 64'(p.wdata));
          check("setup_pwrite", 64'(bus.m_pwrite), 64'(p.write));
          check("setup_pstrb", 64'(bus.m_pstrb), p.write ? 64'(p.strb) : 64'd0);
          check("setup_pprot", 64'(bus.m_pprot), 0);
        end
        bus.m_pready  = 1'($urandom);
        bus.m_prdata  = DW'($urandom);
        bus.m_pslverr = 1'($urandom);
      end else if (bus.m_psel === 1'b1 && bus.m_penable === 1'b1 && have) begin
        total++;
        if (acc >= TMO) begin
          bad++;
          $display("FAIL access_overrun: actual=%0d required<%0d cyc=%0d", acc + 1, TMO + 1, cyc);
        end
        check("access_paddr", 64'(bus.m_paddr), 64'(p.addr));
        check("access_pwdata", 64'(bus.m_pwdata), 64'(p.wdata));
        check("access_pstrb", 64'(bus.m_pstrb), p.write ? 64'(p.strb) : 64'd0);
        if (acc == p.waits) begin
          bus.m_pready  = 1'b1;
          bus.m_prdata  = p.rdata;
          bus.m_pslverr = p.slverr;
        end else begin
          bus.m_pready  = 1'b0;
          bus.m_prdata  = DW'($urandom);
          bus.m_pslverr = 1'($urandom);
        end
        acc++;
      end else begin
        bus.m_pready  = 1'($urandom);
        bus.m_prdata  = DW'($urandom);
        bus.m_pslverr = 1'($urandom);
      end
    end
  end

  // Response monitor: pops the scoreboard on a new response and holds it until the handshake.
  initial begin : monitor
    exp_t e;
    bit   have;
    bit   hs_last;
    int   stall;
    int   resp_idx;
    have = 0; hs_last = 0; stall = 0; resp_idx = 0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        have = 0;
        hs_last = 0;
        bus.rsp_ready = 1'b0;
        continue;
      end
      if (hs_last) begin
        check("post_hs_rsp_valid", 64'(bus.rsp_valid), 0);
        check("post_hs_cmd_ready", 64'(bus.cmd_ready), 1);
        hs_last = 0;
      end
      if (bus.rsp_valid === 1'b1) begin
        if (!have) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_rsp");
          end else begin
            e = exp_q.pop_front();
            have = 1;
            check("rsp_latency", 64'(cyc), 64'(e.valid_cyc));
            stall = (resp_idx == 0 || $urandom_range(0, 4) == 0) ? 5 : int'($urandom_range(0, 2));
            resp_idx++;
          end
        end
        if (have) begin
          check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
          check("rsp_slverr", 64'(bus.rsp_slverr), 64'(e.slverr));
          check("rsp_timeout", 64'(bus.rsp_timeout), 64'(e.timeout));
          check("rsp_cmd_ready", 64'(bus.cmd_ready), 0);
          check("rsp_psel", 64'(bus.m_psel), 0);
          if (stall == 0) begin
            bus.rsp_ready = 1'b1;
            have = 0;
            hs_last = 1;
          end else begin
            bus.rsp_ready = 1'b0;
            stall--;
          end
        end else begin
          bus.rsp_ready = 1'b1;
        end
      end else begin
        bus.rsp_ready = 1'($urandom);
      end
    end
  end

endmodule
